// File: rtl/dma_ch_arbiter.sv
// dma_ch_arbiter: round-robin burst arbiter that connects one of CH_NUM channel
// FIFO read ports to a shared downstream path. Each grant forwards up to
// burst_len_i beats, tags every beat with its channel ID, and marks the final
// beat of a full burst.
//
// Optional build macro: DMA_ARB_CH0_PRIO_EN gives channel 0 absolute priority
// at every arbitration. The pointer only moves on grants to the other channels,
// so round-robin among those channels is preserved. When the macro is not
// defined, the arbiter is pure round-robin.
//
// Handshake: a beat moves on a cycle where valid and ready are both high at the
// rising edge. valid never depends on ready. In XFER the granted channel's
// valid/data are passed combinationally to out_*, and out_ready_i is passed
// combinationally back to that channel's ch_ready_o bit.
module dma_ch_arbiter #(
    parameter int CH_NUM     = 4,
    parameter int DATA_WD    = 8,
    parameter int BLEN_WD    = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [CH_NUM-1:0]             ch_en_i,
    input  logic [CH_NUM-1:0]             ch_valid_i,
    input  logic [CH_NUM*DATA_WD-1:0]     ch_data_i,
    output logic [CH_NUM-1:0]             ch_ready_o,
    input  logic [BLEN_WD-1:0]            burst_len_i,
    output logic                          out_valid_o,
    output logic [DATA_WD-1:0]            out_data_o,
    output logic [$clog2(CH_NUM)-1:0]     out_ch_o,
    output logic                          out_last_o,
    input  logic                          out_ready_i,
    output logic                          busy_o,
    output logic [CH_NUM-1:0]             grant_o
);

    localparam int CH_WD = $clog2(CH_NUM);
    localparam int ST_WD = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CH_WD-1:0]    ptr_q, ptr_d;
    logic [CH_WD-1:0]    gnt_id_q, gnt_id_d;
    logic [CH_NUM-1:0]   grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [BLEN_WD-1:0]  len_q, len_d;
    logic [BLEN_WD-1:0]  cnt_q, cnt_d;
    logic [ST_WD-1:0]    starve_q, starve_d;

    logic [CH_NUM-1:0]   eligible;
    logic                sel_found;
    logic [CH_WD-1:0]    sel_id;
    logic [CH_WD-1:0]    cand;
    logic [DATA_WD-1:0]  ch_data_arr [CH_NUM];
    logic                gnt_valid;
    logic [DATA_WD-1:0]  gnt_data;
    logic [BLEN_WD-1:0]  last_idx;
    logic                fire;

    assign eligible  = ch_valid_i & ch_en_i;
    assign gnt_valid = ch_valid_i[gnt_id_q];
    assign gnt_data  = ch_data_arr[gnt_id_q];
    // len_q is never 0, so this subtraction cannot underflow.
    assign last_idx  = len_q - BLEN_WD'(1);
    assign fire      = out_valid_o & out_ready_i;

    // Split the packed channel data bus into one word per channel.
    always_comb begin
        for (int n = 0; n < CH_NUM; n++) begin
            ch_data_arr[n] = ch_data_i[n*DATA_WD +: DATA_WD];
        end
    end

    // Round-robin pick: the first eligible channel after the last grant. Channel 0 overrides when the priority build is enabled.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = '0;
        for (int i = 1; i <= CH_NUM; i++) begin
            // CH_NUM is a power of two, so the index wraps naturally.
            cand = ptr_q + CH_WD'(i);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
`ifdef DMA_ARB_CH0_PRIO_EN
        if (eligible[0]) begin
            sel_found = 1'b1;
            sel_id    = '0;
        end
`endif
    end

    // Datapath forwarding from the granted channel. All outputs are held at 0 while reset is asserted.
    always_comb begin
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_ch_o    = '0;
        out_last_o  = 1'b0;
        ch_ready_o  = '0;
        if (rstn_i && (state_q == ST_XFER)) begin
            out_valid_o          = gnt_valid;
            out_data_o           = gnt_data;
            out_ch_o             = gnt_id_q;
            out_last_o           = gnt_valid && (cnt_q == last_idx);
            ch_ready_o[gnt_id_q] = out_ready_i;
        end
    end

    assign busy_o  = rstn_i & busy_q;
    assign grant_o = rstn_i ? grant_q : '0;

    // Next-state logic: grant in IDLE. In XFER, count beats and starved cycles, and release the grant on the last beat or on starvation.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d  = ST_XFER;
                    gnt_id_d = sel_id;
                    grant_d  = CH_NUM'(1) << sel_id;
                    busy_d   = 1'b1;
                    // A zero length is treated as a single-beat burst.
                    len_d    = (burst_len_i == '0) ? BLEN_WD'(1) : burst_len_i;
                    cnt_d    = '0;
                    starve_d = '0;
`ifdef DMA_ARB_CH0_PRIO_EN
                    if (sel_id != '0) begin
                        ptr_d = sel_id;
                    end
`else
                    ptr_d = sel_id;
`endif
                end
            end
            ST_XFER: begin
                if (fire) begin
                    starve_d = '0;
                    if (cnt_q == last_idx) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + BLEN_WD'(1);
                    end
                end else if (!gnt_valid) begin
                    // Only an empty FIFO counts toward starvation. Back-pressure from downstream does not.
                    if (starve_q == ST_WD'(STARVE_MAX - 1)) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        busy_d   = 1'b0;
                        cnt_d    = '0;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + ST_WD'(1);
                    end
                end else begin
                    starve_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset. The pointer resets to the last channel, so channel 0 is searched first.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= CH_WD'(CH_NUM - 1);
            gnt_id_q <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            len_q    <= BLEN_WD'(1);
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_dma_ch_arbiter.sv
// Directed testbench for dma_ch_arbiter with its default parameters. A small
// FIFO model on each channel supplies the beats. Inputs change 1 time unit after
// each rising edge, and outputs are sampled on the falling edge.
module tb_dma_ch_arbiter;

    localparam int CH_NUM  = 4;
    localparam int DATA_WD = 8;
    localparam int BLEN_WD = 8;

    logic                      clk = 1'b0;
    logic                      rstn_i;
    logic [CH_NUM-1:0]         ch_en_i;
    logic [CH_NUM-1:0]         ch_valid_i;
    logic [CH_NUM*DATA_WD-1:0] ch_data_i;
    logic [CH_NUM-1:0]         ch_ready_o;
    logic [BLEN_WD-1:0]        burst_len_i;
    logic                      out_valid_o;
    logic [DATA_WD-1:0]        out_data_o;
    logic [1:0]                out_ch_o;
    logic                      out_last_o;
    logic                      out_ready_i;
    logic                      busy_o;
    logic [CH_NUM-1:0]         grant_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Channel FIFO model.
    logic [DATA_WD-1:0] fifo_mem [CH_NUM][32];
    int                 head [CH_NUM];
    int                 tail [CH_NUM];
    logic [CH_NUM-1:0]  fire_mask;

    // Beats observed downstream.
    logic [DATA_WD-1:0] obs_data [$];
    logic [1:0]         obs_ch   [$];
    logic               obs_last [$];

    always #5 clk = ~clk;

    dma_ch_arbiter #(
        .CH_NUM     (CH_NUM),
        .DATA_WD    (DATA_WD),
        .BLEN_WD    (BLEN_WD),
        .STARVE_MAX (4)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .ch_en_i     (ch_en_i),
        .ch_valid_i  (ch_valid_i),
        .ch_data_i   (ch_data_i),
        .ch_ready_o  (ch_ready_o),
        .burst_len_i (burst_len_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ch_o    (out_ch_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .grant_o     (grant_o)
    );

    task automatic refresh();
        for (int n = 0; n < CH_NUM; n++) begin
            ch_valid_i[n] = (head[n] != tail[n]);
            ch_data_i[n*DATA_WD +: DATA_WD] = (head[n] != tail[n]) ? fifo_mem[n][head[n]] : '0;
        end
    endtask

    task automatic enqueue(input int n, input logic [DATA_WD-1:0] d);
        fifo_mem[n][tail[n]] = d;
        tail[n] = tail[n] + 1;
    endtask

    // Falling-edge sample: latch this cycle's handshakes and log downstream beats.
    task automatic sample();
        @(negedge clk);
        fire_mask = ch_ready_o & ch_valid_i;
        if (out_valid_o && out_ready_i) begin
            obs_data.push_back(out_data_o);
            obs_ch.push_back(out_ch_o);
            obs_last.push_back(out_last_o);
        end
    endtask

    // Rising edge: pop the FIFO entries that were accepted and present the next heads.
    task automatic advance();
        @(posedge clk);
        #1;
        for (int n = 0; n < CH_NUM; n++) begin
            if (fire_mask[n]) head[n] = head[n] + 1;
        end
        fire_mask = '0;
        refresh();
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rstn_i      = 1'b0;
        out_ready_i = 1'b0;
        for (int n = 0; n < CH_NUM; n++) begin
            head[n] = 0;
            tail[n] = 0;
        end
        fire_mask = '0;
        refresh();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rstn_i = 1'b1;
        obs_data.delete();
        obs_ch.delete();
        obs_last.delete();
    endtask

    task automatic test_reset();
        rstn_i      = 1'b0;
        ch_en_i     = 4'b1111;
        burst_len_i = 8'd2;
        out_ready_i = 1'b0;
        fire_mask   = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            head[n] = 0;
            tail[n] = 0;
            enqueue(n, DATA_WD'(8'h40 + n));
        end
        refresh();
        for (int i = 0; i < 3; i++) begin
            sample();
            vec_cnt++;
            if ({out_valid_o, ch_ready_o, grant_o, busy_o, out_last_o, out_data_o, out_ch_o} !== '0) begin
                err_cnt++;
                $display("FAIL reset_quiet cyc%0d: valid=%b ready=%b grant=%b busy=%b last=%b data=%h ch=%0d, all must be 0",
                         i, out_valid_o, ch_ready_o, grant_o, busy_o, out_last_o, out_data_o, out_ch_o);
            end
            advance();
        end
        rstn_i = 1'b1;
        sample();
        vec_cnt++;
        if (grant_o !== 4'b0000 || busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_release_idle: grant=%b busy=%b valid=%b, required 0000/0/0", grant_o, busy_o, out_valid_o);
        end
        advance();
        sample();
        vec_cnt++;
        if (grant_o !== 4'b0001 || busy_o !== 1'b1 || out_valid_o !== 1'b1 || out_ch_o !== 2'd0 || out_data_o !== 8'h40) begin
            err_cnt++;
            $display("FAIL reset_first_grant: grant=%b busy=%b valid=%b ch=%0d data=%h, required 0001/1/1/0/40",
                     grant_o, busy_o, out_valid_o, out_ch_o, out_data_o);
        end
        vec_cnt++;
        if (ch_ready_o !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_ready_follows: ch_ready=%b, required 0000 with out_ready low", ch_ready_o);
        end
        advance();
    endtask

    task automatic test_single_burst();
        logic [7:0] ev;
        do_reset();
        ch_en_i     = 4'b1111;
        burst_len_i = 8'd4;
        out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) enqueue(2, DATA_WD'(8'hA0 + k));
        refresh();
        // Bit i is the expected out_valid_o in cycle i: the first grant, then 4 beats, one idle cycle, and 2 beats.
        ev = 8'b1101_1110;
        for (int i = 0; i < 14; i++) begin
            sample();
            if (i < 8) begin
                vec_cnt++;
                if (out_valid_o !== ev[i]) begin
                    err_cnt++;
                    $display("FAIL single_valid cyc%0d: got %b required %b", i, out_valid_o, ev[i]);
                end
            end
            advance();
            // These length changes happen mid-burst and must not affect the burst already granted.
            if (i == 1) burst_len_i = 8'd2;
            if (i == 3) burst_len_i = 8'd4;
        end
        vec_cnt++;
        if (obs_data.size() != 6) begin
            err_cnt++;
            $display("FAIL single_count: got %0d beats required 6", obs_data.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                vec_cnt++;
                if (obs_data[k] !== DATA_WD'(8'hA0 + k) || obs_ch[k] !== 2'd2 || obs_last[k] !== (k == 3)) begin
                    err_cnt++;
                    $display("FAIL single_beat%0d: data=%h ch=%0d last=%b, required %h/2/%b",
                             k, obs_data[k], obs_ch[k], obs_last[k], 8'hA0 + k, (k == 3));
                end
            end
        end
        vec_cnt++;
        if (busy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_starve_release: busy=%b required 0", busy_o);
        end
    endtask

    task automatic test_round_robin();
        int ch;
        int base;
        do_reset();
        ch_en_i     = 4'b1111;
        burst_len_i = 8'd2;
        out_ready_i = 1'b1;
        for (int n = 0; n < CH_NUM; n++) begin
            for (int k = 0; k < 4; k++) enqueue(n, DATA_WD'(n * 16 + k));
        end
        refresh();
        for (int i = 0; i < 15; i++) begin
            sample();
            vec_cnt++;
            if (busy_o !== (i % 3 != 0)) begin
                err_cnt++;
                $display("FAIL rr_busy cyc%0d: got %b required %b", i, busy_o, (i % 3 != 0));
            end
            advance();
        end
        vec_cnt++;
        if (obs_data.size() != 10) begin
            err_cnt++;
            $display("FAIL rr_count: got %0d beats required 10", obs_data.size());
        end else begin
            for (int b = 0; b < 5; b++) begin
                ch   = b % 4;
                base = (b / 4) * 2;
                for (int j = 0; j < 2; j++) begin
                    vec_cnt++;
                    if (obs_ch[b*2+j] !== 2'(ch) || obs_data[b*2+j] !== DATA_WD'(ch * 16 + base + j) ||
                        obs_last[b*2+j] !== (j == 1)) begin
                        err_cnt++;
                        $display("FAIL rr_burst%0d_beat%0d: ch=%0d data=%h last=%b, required %0d/%h/%b",
                                 b, j, obs_ch[b*2+j], obs_data[b*2+j], obs_last[b*2+j], ch, ch * 16 + base + j, (j == 1));
                    end
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        ch_en_i     = 4'b1111;
        burst_len_i = 8'd3;
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) enqueue(1, DATA_WD'(8'hB0 + k));
        refresh();
        for (int i = 0; i < 10; i++) begin
            sample();
            if (i >= 2 && i <= 6) begin
                vec_cnt++;
                if (out_valid_o !== 1'b1 || out_data_o !== 8'hB1 || ch_ready_o !== 4'b0000 ||
                    busy_o !== 1'b1 || out_last_o !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL bp_hold cyc%0d: valid=%b data=%h ready=%b busy=%b last=%b, required 1/b1/0000/1/0",
                             i, out_valid_o, out_data_o, ch_ready_o, busy_o, out_last_o);
                end
            end
            if (i == 9) begin
                vec_cnt++;
                if (busy_o !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL bp_idle_after: busy=%b required 0", busy_o);
                end
            end
            advance();
            if (i == 1) out_ready_i = 1'b0;
            if (i == 6) out_ready_i = 1'b1;
        end
        vec_cnt++;
        if (obs_data.size() != 3) begin
            err_cnt++;
            $display("FAIL bp_count: got %0d beats required 3", obs_data.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vec_cnt++;
                if (obs_data[k] !== DATA_WD'(8'hB0 + k) || obs_last[k] !== (k == 2)) begin
                    err_cnt++;
                    $display("FAIL bp_beat%0d: data=%h last=%b, required %h/%b", k, obs_data[k], obs_last[k], 8'hB0 + k, (k == 2));
                end
            end
        end
    endtask

    task automatic test_starvation();
        do_reset();
        ch_en_i     = 4'b1111;
        burst_len_i = 8'd8;
        out_ready_i = 1'b1;
        enqueue(3, 8'hC0);
        enqueue(3, 8'hC1);
        refresh();
        for (int i = 0; i < 9; i++) begin
            sample();
            vec_cnt++;
            if (out_last_o !== 1'b0) begin
                err_cnt++;
                $display("FAIL starve_no_last cyc%0d: last=%b required 0", i, out_last_o);
            end
            if (i >= 3 && i <= 6) begin
                vec_cnt++;
                if (busy_o !== 1'b1 || grant_o !== 4'b1000 || out_valid_o !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL starve_wait cyc%0d: busy=%b grant=%b valid=%b, required 1/1000/0", i, busy_o, grant_o, out_valid_o);
                end
            end
            if (i == 7) begin
                vec_cnt++;
                if (busy_o !== 1'b0 || grant_o !== 4'b0000) begin
                    err_cnt++;
                    $display("FAIL starve_release: busy=%b grant=%b, required 0/0000", busy_o, grant_o);
                end
            end
            if (i == 8) begin
                vec_cnt++;
                if (grant_o !== 4'b0010 || out_ch_o !== 2'd1 || out_data_o !== 8'hD0 || out_valid_o !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL starve_next_grant: grant=%b ch=%0d data=%h valid=%b, required 0010/1/d0/1",
                             grant_o, out_ch_o, out_data_o, out_valid_o);
                end
            end
            advance();
            if (i == 0) begin
                enqueue(1, 8'hD0);
                refresh();
            end
        end
        vec_cnt++;
        if (obs_data.size() != 3 || obs_data[0] !== 8'hC0 || obs_data[1] !== 8'hC1 || obs_data[2] !== 8'hD0 ||
            obs_ch[0] !== 2'd3 || obs_ch[1] !== 2'd3 || obs_ch[2] !== 2'd1) begin
            err_cnt++;
            $display("FAIL starve_beats: got %0d beats, required C0,C1 from ch3 then D0 from ch1", obs_data.size());
        end
    endtask

    task automatic test_enable_len0();
        do_reset();
        ch_en_i     = 4'b1110;
        burst_len_i = 8'd0;
        out_ready_i = 1'b1;
        enqueue(0, 8'h50);
        enqueue(0, 8'h51);
        enqueue(2, 8'hE0);
        enqueue(2, 8'hE1);
        refresh();
        for (int i = 0; i < 8; i++) begin
            sample();
            vec_cnt++;
            if (grant_o[0] !== 1'b0 || ch_ready_o[0] !== 1'b0) begin
                err_cnt++;
                $display("FAIL en_ch0_masked cyc%0d: grant=%b ready=%b, required bit0 low", i, grant_o, ch_ready_o);
            end
            advance();
        end
        vec_cnt++;
        if (obs_data.size() != 2) begin
            err_cnt++;
            $display("FAIL len0_count: got %0d beats required 2", obs_data.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                vec_cnt++;
                if (obs_data[k] !== DATA_WD'(8'hE0 + k) || obs_ch[k] !== 2'd2 || obs_last[k] !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL len0_beat%0d: data=%h ch=%0d last=%b, required %h/2/1", k, obs_data[k], obs_ch[k], obs_last[k], 8'hE0 + k);
                end
            end
        end
        vec_cnt++;
        if (head[0] != 0) begin
            err_cnt++;
            $display("FAIL en_ch0_untouched: %0d pops from ch0 required 0", head[0]);
        end
    endtask

    task automatic test_ch0_prio();
        int exp_ch [6];
        int nxt [2];
`ifdef DMA_ARB_CH0_PRIO_EN
        exp_ch = '{0, 0, 0, 1, 1, 1};
`else
        exp_ch = '{0, 1, 0, 1, 0, 1};
`endif
        do_reset();
        ch_en_i     = 4'b1111;
        burst_len_i = 8'd1;
        out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            enqueue(0, DATA_WD'(8'h60 + k));
            enqueue(1, DATA_WD'(8'h70 + k));
        end
        refresh();
        for (int i = 0; i < 12; i++) cyc();
        nxt[0] = 0;
        nxt[1] = 0;
        vec_cnt++;
        if (obs_data.size() != 6) begin
            err_cnt++;
            $display("FAIL prio_count: got %0d beats required 6", obs_data.size());
        end else begin
            for (int b = 0; b < 6; b++) begin
                vec_cnt++;
                if (obs_ch[b] !== 2'(exp_ch[b]) ||
                    obs_data[b] !== DATA_WD'(8'h60 + exp_ch[b] * 16 + nxt[exp_ch[b]])) begin
                    err_cnt++;
                    $display("FAIL prio_order%0d: ch=%0d data=%h, required ch %0d data %h",
                             b, obs_ch[b], obs_data[b], exp_ch[b], 8'h60 + exp_ch[b] * 16 + nxt[exp_ch[b]]);
                end
                nxt[exp_ch[b]] = nxt[exp_ch[b]] + 1;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        ch_en_i     = 4'b1111;
        burst_len_i = 8'd4;
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) enqueue(1, DATA_WD'(8'h80 + k));
        enqueue(2, 8'h90);
        refresh();
        cyc();
        cyc();
        rstn_i = 1'b0;
        sample();
        vec_cnt++;
        if ({out_valid_o, ch_ready_o, grant_o, busy_o, out_last_o} !== '0) begin
            err_cnt++;
            $display("FAIL mid_reset_quiet: valid=%b ready=%b grant=%b busy=%b last=%b, all must be 0",
                     out_valid_o, ch_ready_o, grant_o, busy_o, out_last_o);
        end
        advance();
        rstn_i = 1'b1;
        sample();
        vec_cnt++;
        if (busy_o !== 1'b0 || grant_o !== 4'b0000 || out_valid_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_reset_idle: busy=%b grant=%b valid=%b, required 0/0000/0", busy_o, grant_o, out_valid_o);
        end
        advance();
        sample();
        vec_cnt++;
        if (grant_o !== 4'b0010 || out_data_o !== 8'h81 || out_last_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_reset_regrant: grant=%b data=%h last=%b, required 0010/81/0", grant_o, out_data_o, out_last_o);
        end
        advance();
        vec_cnt++;
        if (obs_data.size() < 1 || obs_data[0] !== 8'h80 || obs_last[0] !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_reset_aborted: %0d beats logged, required first beat 80 with no last", obs_data.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_back_pressure();
        test_starvation();
        test_enable_len0();
        test_ch0_prio();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dma_ch_arbiter.md
Name: dma_ch_arbiter

Overview:
- Round-robin burst arbiter that shares one downstream data path between CH_NUM per-channel DMA FIFOs (valid/ready read side).
- Grants one channel at a time and forwards up to burst_len_i beats from it.
- Tags each beat with its channel ID and marks the final beat of a full burst.
- Sits between the four channel FIFOs and the shared bus write engine.

Parameters:
- CH_NUM, 4, number of requesting channels (power of 2, ≥2)
- DATA_WD, 8, beat data width
- BLEN_WD, 8, width of burst length input
- STARVE_MAX, 4, consecutive cycles the granted channel may be not-valid before its grant is released early

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rstn_i  in  1  synchronous active-low reset
- ch_en_i  in  CH_NUM  per-channel enable; only enabled channels are eligible
- ch_valid_i  in  CH_NUM  per-channel FIFO rd_valid
- ch_data_i  in  CH_NUM*DATA_WD  packed channel data, ch n at [n*DATA_WD +: DATA_WD]
- ch_ready_o  out  CH_NUM  per-channel FIFO rd_ready
- burst_len_i  in  BLEN_WD  beats per burst, sampled at grant
- out_valid_o  out  1  downstream valid
- out_data_o  out  DATA_WD  downstream data
- out_ch_o  out  $clog2(CH_NUM)  channel ID of current beat
- out_last_o  out  1  final beat of a full burst
- out_ready_i  in  1  downstream ready
- busy_o  out  1  high while a grant is held
- grant_o  out  CH_NUM  one-hot current grant, 0 when idle

Behaviour:
- Reset: rstn_i sampled low at a clock edge.
  - State goes to IDLE; grant_o=0; busy_o=0; beat and starve counters 0.
  - Last-grant pointer set to CH_NUM-1, so ch0 has first priority.
  - All outputs 0 while in reset, including ch_ready_o and out_valid_o.
  - A reset mid-burst aborts the burst with no last beat.
- Eligible set: ch_valid_i & ch_en_i.
- States: IDLE, XFER.
- IDLE:
  - Outputs quiet: out_valid_o=0, ch_ready_o=0.
  - If eligible≠0, select the first eligible channel in search order ptr+1, ptr+2, … ptr+CH_NUM (mod CH_NUM).
  - Register grant, ptr←selected, and len←burst_len_i; burst_len_i=0 is treated as 1.
  - Go to XFER at the next edge. Arbitration latency is 1 cycle.
- XFER, granted channel g:
  - Forwarding is combinational: out_valid_o=ch_valid_i[g]; out_data_o=ch_data_i[g]; out_ch_o=g; ch_ready_o[g]=out_ready_i; all other ch_ready_o bits 0.
  - busy_o=1; grant_o=one-hot(g).
  - fire = out_valid_o & out_ready_i; each fire increments the beat counter.
  - out_last_o = out_valid_o & (cnt==len-1).
  - Burst end: on the fire with cnt==len-1 go to IDLE and clear cnt.
  - Starve: the counter increments on cycles with ch_valid_i[g]=0 and clears on ch_valid_i[g]=1. On reaching STARVE_MAX, go to IDLE with no last beat. The counter clears on any grant.
  - Back-pressure (out_ready_i=0) never counts as starvation.
  - ch_en_i[g] deasserting mid-burst does not abort; the burst completes or starves out.
  - burst_len_i changes during XFER are ignored.
- One idle cycle always separates consecutive bursts, even for the same channel.
- Fairness: a channel cannot be re-granted while another eligible channel is waiting, because the pointer rotates past it.
- Beat counter width is BLEN_WD; no wrap is possible because cnt < len ≤ 2^BLEN_WD-1.

Optional Feature:
- Macro: DMA_ARB_CH0_PRIO_EN
- Defined:
  - In IDLE, if ch0 is eligible it wins regardless of the pointer.
  - The pointer is updated only on grants to ch1..CH_NUM-1, so round-robin among the others is preserved.
  - No preemption of an in-progress burst.
- Undefined: pure round-robin as above.

Test Plan:
- Reset/idle: hold rstn_i=0 for 3 cycles, all ch_valid_i=1 → all outputs 0. Release → grant_o=0001 one cycle later, busy_o=1.
- Single burst: ch2 only, burst_len_i=4, 6 beats A0..A5 queued, out_ready_i=1 → 4 beats A0..A3 with out_ch_o=2, out_last_o only on A3. Then 1 idle cycle, then A4, A5 in a new burst.
- Round-robin: all 4 channels valid and enabled, len=2 → grant order ch0, ch1, ch2, ch3, ch0. Each burst is 2 beats with last on the 2nd.
- Back-pressure: ch1 len=3, out_ready_i low for 5 cycles mid-burst → no early release, data held stable, exactly 3 beats delivered.
- Starvation: ch3 len=8 supplies 2 beats then valid drops, STARVE_MAX=4 → release to IDLE after 4 empty cycles, out_last_o never asserted, next eligible channel granted.
- Enable/len0: ch_en_i=1110 with ch0 valid → ch0 never granted. burst_len_i=0 → 1-beat bursts with last on every beat. With DMA_ARB_CH0_PRIO_EN, ch0 valid plus others → ch0 granted at every IDLE.
